// File: rtl/tx_serializer_if.sv
// Word-side and line-side signals of the serializer, bundled so the producer and
// the serializer see the same widths through their modports.
interface tx_serializer_if #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] Parallel_Data;
  logic             Data_Valid;
  logic             TrainEn;
  logic             Ready;
  logic             Serial_out;
  logic             Frame_start;
  logic             Training;
  logic [CNT_W-1:0] Word_Count;

  modport master (
    output Parallel_Data, Data_Valid, TrainEn,
    input  Ready, Serial_out, Frame_start, Training, Word_Count
  );

  modport slave (
    input  Parallel_Data, Data_Valid, TrainEn,
    output Ready, Serial_out, Frame_start, Training, Word_Count
  );
endinterface

// File: rtl/tx_serializer.sv
// LSB-first word serializer toward an RX CDR, with a 1010 lock-training pattern
// that is only started and stopped on word and bit-pair boundaries.
module tx_serializer #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
) (
  input  logic          BitCLK,
  input  logic          Reset,
  tx_serializer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, TRAIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic             serial_q, serial_d;
  logic             frame_q, frame_d;
  logic             training_q, training_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic lastBit;
  logic boundary;
  logic ready;

  // A word boundary is either idle or the cycle carrying the final bit of a word.
  always_comb begin
    lastBit  = (bitCnt_q == LastBit);
    boundary = (state_q == IDLE) || ((state_q == SEND) && lastBit);
    ready    = Reset && !bus.TrainEn && boundary;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    serial_d   = serial_q;
    frame_d    = frame_q;
    training_d = training_q;
    count_d    = count_q;

    if (ready && bus.Data_Valid) begin
      state_d    = SEND;
      serial_d   = bus.Parallel_Data[0];
      shift_d    = bus.Parallel_Data >> 1;
      bitCnt_d   = '0;
      frame_d    = 1'b1;
      training_d = 1'b0;
      count_d    = count_q + 1'b1;
    end else if (boundary && bus.TrainEn) begin
      state_d    = TRAIN;
      serial_d   = 1'b1;
      frame_d    = 1'b0;
      training_d = 1'b1;
    end else begin
      case (state_q)
        SEND: begin
          frame_d = 1'b0;
          if (lastBit) begin
            state_d  = IDLE;
            serial_d = 1'b0;
          end else begin
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
        // Leave training only once the 0 of a 1,0 pair is already on the line.
        TRAIN: begin
          if (!serial_q && !bus.TrainEn) begin
            state_d    = IDLE;
            serial_d   = 1'b0;
            training_d = 1'b0;
          end else begin
            serial_d = !serial_q;
          end
        end
        default: begin
          state_d    = IDLE;
          serial_d   = 1'b0;
          frame_d    = 1'b0;
          training_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge BitCLK) begin
    if (!Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      serial_q   <= 1'b0;
      frame_q    <= 1'b0;
      training_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      serial_q   <= serial_d;
      frame_q    <= frame_d;
      training_q <= training_d;
      count_q    <= count_d;
    end
  end

  assign bus.Ready       = ready;
  assign bus.Serial_out  = serial_q;
  assign bus.Frame_start = frame_q;
  assign bus.Training    = training_q;
  assign bus.Word_Count  = count_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: stimulus queues the expected line bits per
// cycle, an independent monitor compares the line against them every cycle.
module tb_tx_serializer;

  localparam int WIDTH = 10;
  localparam int CNT_W = 8;

  logic BitCLK = 1'b0;
  logic Reset;

  tx_serializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tx_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .BitCLK (BitCLK),
    .Reset  (Reset),
    .bus    (bus.slave)
  );

  always #5 BitCLK = ~BitCLK;

  typedef struct packed {
    int unsigned tgt;
    logic        so;
    logic        fs;
    logic        tr;
  } exp_t;

  exp_t        expQ[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  bit          monEn = 1'b0;

  always @(posedge BitCLK) cyc <= cyc + 1;

  // Any cycle without a queued expectation must show an idle line.
  always @(negedge BitCLK) begin
    exp_t       e;
    logic [2:0] want;
    logic [2:0] got;
    if (monEn) begin
      want = 3'b000;
      while (expQ.size() > 0 && expQ[0].tgt < cyc) begin
        e = expQ.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL stale_expectation tgt=%0d seen_at_cycle=%0d", e.tgt, cyc);
      end
      if (expQ.size() > 0 && expQ[0].tgt == cyc) begin
        e    = expQ.pop_front();
        want = {e.so, e.fs, e.tr};
      end
      got = {bus.Serial_out, bus.Frame_start, bus.Training};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL line cycle=%0d so/fs/tr got=%b want=%b", cyc, got, want);
      end
    end
  end

  task automatic pushBit(input int unsigned tgt, input logic so, input logic fs, input logic tr);
    exp_t e;
    e.tgt = tgt;
    e.so  = so;
    e.fs  = fs;
    e.tr  = tr;
    expQ.push_back(e);
  endtask

  task automatic pushWord(input int unsigned start, input logic [WIDTH-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) pushBit(start + i, w[i], (i == 0), 1'b0);
  endtask

  task automatic pushTrain(input int unsigned start, input int n);
    for (int i = 0; i < n; i++) pushBit(start + i, ((i % 2) == 0), 1'b0, 1'b1);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge BitCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic dv, input logic [WIDTH-1:0] pd, input logic te);
    Reset              = r;
    bus.Data_Valid     = dv;
    bus.Parallel_Data  = pd;
    bus.TrainEn        = te;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    stepCycles(2);
    monEn = 1'b1;
    checkOutput("reset_ready", 32'(bus.Ready), 0);
    checkOutput("reset_count", 32'(bus.Word_Count), 0);
    checkOutput("reset_serial", 32'(bus.Serial_out), 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("ready_after_release", 32'(bus.Ready), 1);

    // Single word 0x2B5: 1,0,1,0,1,1,0,1,0,1 with Frame_start on the first bit.
    applyStimulus(1'b1, 1'b1, 10'h2B5, 1'b0);
    pushWord(cyc + 1, 10'h2B5, 10);
    stepCycles(1);
    checkOutput("t1_count", 32'(bus.Word_Count), 1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    stepCycles(9);
    checkOutput("t1_ready_bit9", 32'(bus.Ready), 1);
    stepCycles(2);

    // Back-to-back 0x3FF then 0x000 with Data_Valid held high.
    applyStimulus(1'b1, 1'b1, 10'h3FF, 1'b0);
    pushWord(cyc + 1, 10'h3FF, 10);
    stepCycles(10);
    applyStimulus(1'b1, 1'b1, 10'h000, 1'b0);
    pushWord(cyc + 1, 10'h000, 10);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    stepCycles(11);
    checkOutput("t2_count", 32'(bus.Word_Count), 3);

    // Training from idle for 7 cycles, Data_Valid high but must be ignored.
    applyStimulus(1'b1, 1'b1, 10'h3A5, 1'b1);
    checkOutput("t3_ready_trainen", 32'(bus.Ready), 0);
    pushTrain(cyc + 1, 8);
    stepCycles(7);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("t3_ready_in_train", 32'(bus.Ready), 0);
    stepCycles(3);
    checkOutput("t3_count", 32'(bus.Word_Count), 3);
    checkOutput("t3_ready_idle", 32'(bus.Ready), 1);

    // TrainEn raised during bit 3 of 0x155: word completes, training follows gaplessly.
    applyStimulus(1'b1, 1'b1, 10'h155, 1'b0);
    pushWord(cyc + 1, 10'h155, 10);
    pushTrain(cyc + 11, 2);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    stepCycles(3);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("t4_ready_midword", 32'(bus.Ready), 0);
    stepCycles(7);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    stepCycles(3);
    checkOutput("t4_count", 32'(bus.Word_Count), 4);

    // Reset while bit 4 is on the line discards the rest of the word.
    applyStimulus(1'b1, 1'b1, 10'h2B5, 1'b0);
    pushWord(cyc + 1, 10'h2B5, 5);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    stepCycles(4);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("t5_ready_in_reset", 32'(bus.Ready), 0);
    stepCycles(1);
    checkOutput("t5_count_cleared", 32'(bus.Word_Count), 0);
    checkOutput("t5_serial_cleared", 32'(bus.Serial_out), 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("t5_ready_release", 32'(bus.Ready), 1);
    stepCycles(12);

    // 256 gapless words wrap the 8-bit word counter back to zero.
    for (int k = 0; k < 256; k++) begin
      w = 10'(k * 37 + 5);
      applyStimulus(1'b1, 1'b1, w, 1'b0);
      pushWord(cyc + 1, w, 10);
      if (k == 255) checkOutput("t6_count_255", 32'(bus.Word_Count), 255);
      stepCycles(1);
      if (k == 0) checkOutput("t6_count_first", 32'(bus.Word_Count), 1);
      stepCycles(9);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("t6_count_wrap", 32'(bus.Word_Count), 0);
    stepCycles(4);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
